// File: rtl/mux9_arb_pkg.sv
// Shared constants and types for the 9-way round-robin packet arbiter.
//   N_REQ    : number of requesters sharing the output channel
//   WIDTH    : beat data width
//   IDX_W    : width of a requester index
//   SEL_NONE : out_sel value meaning "no source yet" (reset value)
//   state_t  : arbitration state (free search / locked to a packet owner)
package mux9_arb_pkg;

  localparam int unsigned N_REQ = 9;
  localparam int unsigned WIDTH = 16;
  localparam int unsigned IDX_W = 4;

  localparam logic [IDX_W-1:0] SEL_NONE = 4'hF;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } state_t;

endpackage

// File: rtl/rr_pick9.sv
// Rotating priority encoder: finds the first set req bit searching from
// (ptr+1) mod N_REQ upward, wrapping N_REQ-1 -> 0.
//   req   : request vector
//   ptr   : index of the most recent winner (search starts just after it)
//   found : at least one request is set
//   idx   : index of the winner (0 when nothing is found)
module rr_pick9
  import mux9_arb_pkg::*;
#(
  parameter int unsigned N_REQ = mux9_arb_pkg::N_REQ,
  parameter int unsigned IDX_W = mux9_arb_pkg::IDX_W
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic             found,
  output logic [IDX_W-1:0] idx
);

  int unsigned      pos;
  logic [IDX_W-1:0] pos_idx;

  // Walk farthest-to-nearest so the nearest match after ptr wins.
  always_comb begin
    found   = 1'b0;
    idx     = '0;
    pos     = 0;
    pos_idx = '0;
    for (int unsigned i = N_REQ; i > 0; i--) begin
      pos     = (32'(ptr) + i) % N_REQ;
      pos_idx = IDX_W'(pos);
      if (req[pos_idx]) begin
        found = 1'b1;
        idx   = pos_idx;
      end
    end
  end

endmodule

// File: rtl/mux9_rr_arbiter.sv
// Round-robin packet arbiter muxing N_REQ requesters onto one registered
// output channel. A multi-beat packet locks the channel to its owner until
// its last beat is taken.
//   clk, areset : clock, asynchronous active-high reset
//   req, last   : per-requester beat valid / end-of-packet flag
//   data_flat   : requester k data at bits [WIDTH*k +: WIDTH]
//   ack         : combinational per-requester beat-taken strobe
//   out_valid, out_ready, out_data, out_last, out_sel : output beat channel
module mux9_rr_arbiter
  import mux9_arb_pkg::*;
#(
  parameter int unsigned N_REQ = mux9_arb_pkg::N_REQ,
  parameter int unsigned WIDTH = mux9_arb_pkg::WIDTH
) (
  input  logic                   clk,
  input  logic                   areset,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ-1:0]       last,
  input  logic [N_REQ*WIDTH-1:0] data_flat,
  output logic [N_REQ-1:0]       ack,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH-1:0]       out_data,
  output logic                   out_last,
  output logic [IDX_W-1:0]       out_sel
);

  state_t           state, state_nx;
  logic [IDX_W-1:0] ptr, ptr_nx;
  logic [IDX_W-1:0] owner, owner_nx;

  logic             slot_free;
  logic             pick_found;
  logic [IDX_W-1:0] pick_idx;
  logic [IDX_W-1:0] cand;
  logic             cand_req;
  logic             cand_last;
  logic [WIDTH-1:0] cand_data;
  logic             grant;

  assign slot_free = !out_valid || out_ready;

  rr_pick9 #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_pick (
    .req   (req),
    .ptr   (ptr),
    .found (pick_found),
    .idx   (pick_idx)
  );

  // Candidate selection, beat mux and ack strobe.
  always_comb begin
    cand      = owner;
    cand_req  = 1'b0;
    cand_last = 1'b0;
    cand_data = '0;
    ack       = '0;
    if (state == ST_IDLE) begin
      cand = pick_idx;
    end
    for (int unsigned k = 0; k < N_REQ; k++) begin
      if (cand == IDX_W'(k)) begin
        cand_req  = req[k];
        cand_last = last[k];
        cand_data = data_flat[k*WIDTH +: WIDTH];
      end
    end
    // In IDLE with no request, pick_idx is 0 and req[0] is 0, so cand_req
    // already encodes pick_found.
    grant = cand_req && slot_free && !areset;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      ack[k] = grant && (cand == IDX_W'(k));
    end
  end

  // Next-state: ptr only moves on IDLE grants; HOLD releases on last beat.
  always_comb begin
    state_nx = state;
    ptr_nx   = ptr;
    owner_nx = owner;
    if (grant) begin
      case (state)
        ST_IDLE: begin
          ptr_nx = cand;
          if (!cand_last) begin
            state_nx = ST_HOLD;
            owner_nx = cand;
          end
        end
        ST_HOLD: begin
          if (cand_last) begin
            state_nx = ST_IDLE;
          end
        end
        default: state_nx = ST_IDLE;
      endcase
    end
  end

  // Arbitration state register; ptr resets to the last index so the first
  // search starts at requester 0.
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      state <= ST_IDLE;
      ptr   <= IDX_W'(N_REQ - 1);
      owner <= '0;
    end else begin
      state <= state_nx;
      ptr   <= ptr_nx;
      owner <= owner_nx;
    end
  end

  // Output beat register: load on grant, drop valid on a bare handshake.
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      out_valid <= 1'b0;
      out_data  <= '1;
      out_last  <= 1'b0;
      out_sel   <= SEL_NONE;
    end else if (grant) begin
      out_valid <= 1'b1;
      out_data  <= cand_data;
      out_last  <= cand_last;
      out_sel   <= cand;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
